// File: rtl/core_control_ldm_pkg.sv
// Shared types for the load/store-multiple sequencer.
// ldm_mode selects the addressing direction and whether the base is pre- or post-adjusted.
package core_control_ldm_pkg;

    typedef enum logic [1:0] {
        LDM_IA = 2'd0,
        LDM_IB = 2'd1,
        LDM_DA = 2'd2,
        LDM_DB = 2'd3
    } ldm_mode;

endpackage

// File: rtl/core_control_ldm_prio.sv
// Lowest-set-bit encoder: o_idx is the position of the least significant 1 in i_vec,
// o_any flags a non-empty vector (o_idx is 0 when the vector is empty).
module core_control_ldm_prio #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_idx = '0;
        // Scan downwards so the lowest set bit is the last one to win.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/core_control_ldm.sv
// Load/store-multiple sequencer: walks a register bitmask in ascending order, issuing one
// memory transaction per selected register, with load writeback and optional base writeback.
module core_control_ldm
    import core_control_ldm_pkg::*;
#(
    parameter int REGS   = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     load,
    input  ldm_mode                  mode,
    input  logic [REGS-1:0]          reg_list,
    input  logic [ADDR_W-1:0]        base,
    input  logic [$clog2(REGS)-1:0]  base_reg,
    input  logic                     base_wb,
    input  logic [DATA_W-1:0]        rd_value,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_data_rd,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(REGS)-1:0]  ra,
    output logic                     mem_start,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data_wr,
    output logic                     wr_en,
    output logic [$clog2(REGS)-1:0]  wr_reg,
    output logic [DATA_W-1:0]        wr_value,
    output logic                     base_wr_en,
    output logic [ADDR_W-1:0]        base_new
);

    localparam int IW = $clog2(REGS);
    localparam int CW = $clog2(REGS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    function automatic logic [CW-1:0] popcount(input logic [REGS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < REGS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [REGS-1:0]     r_list;
    logic [IW-1:0]       r_cur;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_base_new;
    logic                r_load;
    logic                r_bwb;

    logic [CW-1:0]       w_n;
    logic [ADDR_W-1:0]   w_n_ext;
    logic [ADDR_W-1:0]   w_first_addr;
    logic [ADDR_W-1:0]   w_final_base;
    logic [IW-1:0]       w_first_idx;
    logic                w_first_any;
    logic [REGS-1:0]     w_rest;
    logic [IW-1:0]       w_next_idx;
    logic                w_next_any;
    logic                w_xfer;
    logic                w_accept;

    core_control_ldm_prio #(.N(REGS), .IW(IW)) u_prio_first (
        .i_vec (reg_list),
        .o_idx (w_first_idx),
        .o_any (w_first_any)
    );

    // Remaining list once the register currently in flight completes.
    assign w_rest = r_list & ~(REGS'(1) << r_cur);

    core_control_ldm_prio #(.N(REGS), .IW(IW)) u_prio_next (
        .i_vec (w_rest),
        .o_idx (w_next_idx),
        .o_any (w_next_any)
    );

    assign w_n     = popcount(reg_list);
    assign w_n_ext = ADDR_W'(w_n);

    // Address arithmetic is deliberately modulo 2^ADDR_W; wrap-around is legal.
    always_comb begin
        w_first_addr = base;
        w_final_base = base + w_n_ext;
        case (mode)
            LDM_IA: begin
                w_first_addr = base;
                w_final_base = base + w_n_ext;
            end
            LDM_IB: begin
                w_first_addr = base + ADDR_W'(1);
                w_final_base = base + w_n_ext;
            end
            LDM_DA: begin
                w_first_addr = base - w_n_ext + ADDR_W'(1);
                w_final_base = base - w_n_ext;
            end
            LDM_DB: begin
                w_first_addr = base - w_n_ext;
                w_final_base = base - w_n_ext;
            end
            default: begin
                w_first_addr = base;
                w_final_base = base;
            end
        endcase
    end

    assign w_accept = (r_state == S_WAIT) && mem_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_first_any ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT: begin
                if (mem_ready) begin
                    w_next = w_next_any ? S_ISSUE : S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_list     <= '0;
            r_cur      <= '0;
            r_addr     <= '0;
            r_base_new <= '0;
            r_load     <= 1'b0;
            r_bwb      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_list     <= reg_list;
                r_load     <= load;
                r_cur      <= w_first_idx;
                r_addr     <= w_first_addr;
                r_base_new <= w_final_base;
                // A loaded base register overrides the arithmetic writeback.
                r_bwb      <= base_wb && w_first_any && !(load && reg_list[base_reg]);
            end else if (w_accept) begin
                r_list <= w_rest;
                r_cur  <= w_next_idx;
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign w_xfer = (r_state == S_ISSUE) || (r_state == S_WAIT);

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FINISH);
    assign mem_start   = (r_state == S_ISSUE);
    assign mem_write   = w_xfer && !r_load;
    assign mem_addr    = r_addr;
    assign ra          = r_cur;
    assign mem_data_wr = mem_write ? rd_value : '0;
    assign wr_en       = w_accept && r_load;
    assign wr_reg      = wr_en ? r_cur : '0;
    assign wr_value    = wr_en ? mem_data_rd : '0;
    assign base_wr_en  = done && r_bwb;
    assign base_new    = r_base_new;

endmodule

// File: tb/tb_core_control_ldm.sv
// Self-checking bench for core_control_ldm: directed scenarios plus randomized transfers
// checked against a transaction-level model of the expected memory accesses and results.
module tb_core_control_ldm;
    import core_control_ldm_pkg::*;

    localparam int REGS   = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int IW     = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              load;
    ldm_mode           mode;
    logic [REGS-1:0]   reg_list;
    logic [ADDR_W-1:0] base;
    logic [IW-1:0]     base_reg;
    logic              base_wb;
    logic [DATA_W-1:0] rd_value;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data_rd;
    logic              busy, done, mem_start, mem_write, wr_en, base_wr_en;
    logic [IW-1:0]     ra, wr_reg;
    logic [ADDR_W-1:0] mem_addr, base_new;
    logic [DATA_W-1:0] mem_data_wr, wr_value;

    core_control_ldm #(.REGS(REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load(load), .mode(mode),
        .reg_list(reg_list), .base(base), .base_reg(base_reg), .base_wb(base_wb),
        .rd_value(rd_value), .mem_ready(mem_ready), .mem_data_rd(mem_data_rd),
        .busy(busy), .done(done), .ra(ra), .mem_start(mem_start), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data_wr(mem_data_wr), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_value(wr_value), .base_wr_en(base_wr_en), .base_new(base_new)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file and memory environment
    logic [DATA_W-1:0] rf [REGS];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    assign rd_value = rf[ra];

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {2'b10, a};
    endfunction

    // Observations of one transfer
    logic [ADDR_W-1:0] acc_addr[$];
    logic              acc_wr[$];
    logic [DATA_W-1:0] acc_data[$];
    logic [IW-1:0]     wq_reg[$];
    logic [DATA_W-1:0] wq_val[$];
    int done_cyc, bwen_cnt, bwen_bad, unstable, notbusy, spurious_wr;
    logic [ADDR_W-1:0] bnew_seen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic run_xfer(input logic ld, input ldm_mode md, input logic [REGS-1:0] lst,
                            input logic [ADDR_W-1:0] bs, input logic [IW-1:0] br,
                            input logic bwb, input int lat, input bit noise,
                            input int mid_start_cyc, input int abort_acc);
        int cyc, cnt;
        bit pend, pw;
        logic [ADDR_W-1:0] paddr;
        logic pwr;
        logic [IW-1:0] preg, pw_reg;
        logic [DATA_W-1:0] pw_val;
        acc_addr.delete(); acc_wr.delete(); acc_data.delete();
        wq_reg.delete(); wq_val.delete();
        done_cyc = -1; bwen_cnt = 0; bwen_bad = 0; unstable = 0; notbusy = 0;
        spurious_wr = 0; bnew_seen = '0;
        pend = 0; cnt = 0; paddr = '0; pwr = 0; preg = '0;
        @(negedge clk);
        start = 1'b1; load = ld; mode = md; reg_list = lst; base = bs;
        base_reg = br; base_wb = bwb; mem_ready = 1'b0;
        @(posedge clk);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start    = (cyc == mid_start_cyc);
            load     = 1'($urandom);
            mode     = ldm_mode'($urandom_range(0, 3));
            reg_list = REGS'($urandom);
            base     = ADDR_W'($urandom);
            base_reg = IW'($urandom);
            base_wb  = 1'($urandom);
            if (pend && cnt == 0) begin
                mem_ready   = 1'b1;
                mem_data_rd = pwr ? $urandom : mem_rd(paddr);
            end else begin
                mem_ready   = noise && !pend ? 1'($urandom) : 1'b0;
                mem_data_rd = $urandom;
                if (pend) cnt--;
            end
            if (abort_acc >= 0 && pend && acc_addr.size() == abort_acc + 1) begin
                rst_n = 1'b0;
                return;
            end
            #1;
            pw = 0; pw_reg = '0; pw_val = '0;
            if (pend) begin
                if (mem_addr !== paddr || mem_write !== pwr || ra !== preg) unstable++;
            end
            if (pend && mem_ready) begin
                pend = 0;
                if (wr_en) begin
                    wq_reg.push_back(wr_reg); wq_val.push_back(wr_value);
                    pw = 1; pw_reg = wr_reg; pw_val = wr_value;
                end
            end else if (wr_en) begin
                spurious_wr++;
            end
            if (mem_start) begin
                acc_addr.push_back(mem_addr); acc_wr.push_back(mem_write);
                acc_data.push_back(mem_data_wr);
                if (mem_write) mem[mem_addr] = mem_data_wr;
                pend = 1; cnt = lat; paddr = mem_addr; pwr = mem_write; preg = ra;
            end
            if (!busy) notbusy++;
            if (base_wr_en) begin
                bwen_cnt++; bnew_seen = base_new;
                if (!done) bwen_bad++;
            end
            if (done) done_cyc = cyc;
            @(posedge clk);
            if (pw) rf[pw_reg] = pw_val;
            if (done || cyc > 500) break;
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0; mem_data_rd = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; load = 1'b1; mode = LDM_IB; reg_list = '1;
        base = '1; base_reg = '1; base_wb = 1'b1; mem_ready = 1'b1; mem_data_rd = '1;
        for (int i = 0; i < REGS; i++) rf[i] = 32'hC0DE_0000 + i;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, mem_start, mem_write, wr_en, base_wr_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, mem_start, mem_write, wr_en, base_wr_en});
        end
        n_checks++;
        if ({ra, wr_reg, mem_addr, base_new} !== '0) begin
            n_fail++;
            $display("FAIL reset_idx_addr: ra=%0h wr_reg=%0h mem_addr=%0h base_new=%0h expected 0",
                     ra, wr_reg, mem_addr, base_new);
        end
        n_checks++;
        if ({mem_data_wr, wr_value} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: mem_data_wr=%0h wr_value=%0h expected 0", mem_data_wr, wr_value);
        end
        start = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_ia();
        rf[1] = 32'hA; rf[2] = 32'hB; rf[3] = 32'hC;
        run_xfer(1'b0, LDM_IA, 16'h000E, 30'h100, 4'd4, 1'b1, 0, 0, -1, -1);
        n_checks++;
        if (acc_addr.size() != 3) begin
            n_fail++; $display("FAIL store_ia count: got %0d expected 3", acc_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (acc_addr[k] !== 30'h100 + k || acc_data[k] !== 32'hA + k || acc_wr[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL store_ia acc%0d: got %0h@%0h wr=%b expected %0h@%0h wr=1",
                             k, acc_data[k], acc_addr[k], acc_wr[k], 32'hA + k, 30'h100 + k);
                end
            end
        end
        n_checks++;
        if (done_cyc != 7) begin
            n_fail++; $display("FAIL store_ia done_cycle: got %0d expected 7", done_cyc);
        end
        n_checks++;
        if (bwen_cnt != 1 || bnew_seen !== 30'h103) begin
            n_fail++;
            $display("FAIL store_ia base_wb: got cnt=%0d new=%0h expected cnt=1 new=103", bwen_cnt, bnew_seen);
        end
        n_checks++;
        if (wq_reg.size() != 0 || spurious_wr != 0) begin
            n_fail++; $display("FAIL store_ia wr_en: got %0d writes expected 0", wq_reg.size() + spurious_wr);
        end
    endtask

    task automatic test_load_db();
        mem[30'h1FE] = 32'h11; mem[30'h1FF] = 32'h22;
        rf[0] = '0; rf[15] = '0;
        run_xfer(1'b1, LDM_DB, 16'h8001, 30'h200, 4'd5, 1'b1, 0, 0, -1, -1);
        n_checks++;
        if (acc_addr.size() != 2 || acc_addr[0] !== 30'h1FE || acc_addr[1] !== 30'h1FF) begin
            n_fail++;
            $display("FAIL load_db addrs: got n=%0d first=%0h expected 1fe,1ff", acc_addr.size(),
                     acc_addr.size() > 0 ? acc_addr[0] : '0);
        end
        n_checks++;
        if (rf[0] !== 32'h11 || rf[15] !== 32'h22) begin
            n_fail++; $display("FAIL load_db regs: got r0=%0h r15=%0h expected 11,22", rf[0], rf[15]);
        end
        n_checks++;
        if (bwen_cnt != 1 || bnew_seen !== 30'h1FE) begin
            n_fail++;
            $display("FAIL load_db base_wb: got cnt=%0d new=%0h expected cnt=1 new=1fe", bwen_cnt, bnew_seen);
        end
        n_checks++;
        if (done_cyc != 5) begin
            n_fail++; $display("FAIL load_db done_cycle: got %0d expected 5", done_cyc);
        end
    endtask

    task automatic test_load_base_in_list();
        mem[30'h40] = 32'hDEAD_0001; mem[30'h41] = 32'hBEEF_0002;
        rf[1] = '0; rf[2] = 32'h40;
        run_xfer(1'b1, LDM_IA, 16'h0006, 30'h40, 4'd2, 1'b1, 1, 0, -1, -1);
        n_checks++;
        if (rf[1] !== 32'hDEAD_0001 || rf[2] !== 32'hBEEF_0002) begin
            n_fail++;
            $display("FAIL base_in_list regs: got r1=%0h r2=%0h expected dead0001,beef0002", rf[1], rf[2]);
        end
        n_checks++;
        if (bwen_cnt != 0) begin
            n_fail++; $display("FAIL base_in_list base_wr_en: got %0d pulses expected 0", bwen_cnt);
        end
    endtask

    task automatic test_empty();
        run_xfer(1'b0, LDM_IB, 16'h0000, 30'h55, 4'd0, 1'b1, 0, 0, -1, -1);
        n_checks++;
        if (done_cyc != 1) begin
            n_fail++; $display("FAIL empty done_cycle: got %0d expected 1", done_cyc);
        end
        n_checks++;
        if (acc_addr.size() != 0 || bwen_cnt != 0) begin
            n_fail++;
            $display("FAIL empty side_effects: got mem_start=%0d base_wr_en=%0d expected 0,0",
                     acc_addr.size(), bwen_cnt);
        end
    endtask

    task automatic test_da_wrap_wait();
        rf[0] = 32'h1234_5678; rf[1] = 32'h9ABC_DEF0;
        run_xfer(1'b0, LDM_DA, 16'h0003, 30'h0, 4'd9, 1'b0, 3, 0, 3, -1);
        n_checks++;
        if (acc_addr.size() != 2 || acc_addr[0] !== 30'h3FFF_FFFF || acc_addr[1] !== 30'h0) begin
            n_fail++;
            $display("FAIL da_wrap addrs: got n=%0d first=%0h expected 3fffffff,0", acc_addr.size(),
                     acc_addr.size() > 0 ? acc_addr[0] : '0);
        end
        n_checks++;
        if (acc_addr.size() == 2 && (acc_data[0] !== 32'h1234_5678 || acc_data[1] !== 32'h9ABC_DEF0)) begin
            n_fail++;
            $display("FAIL da_wrap data: got %0h,%0h expected 12345678,9abcdef0", acc_data[0], acc_data[1]);
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++; $display("FAIL da_wrap hold: got %0d unstable cycles expected 0", unstable);
        end
        n_checks++;
        if (done_cyc != 11 || notbusy != 0) begin
            n_fail++;
            $display("FAIL da_wrap timing: got done=%0d notbusy=%0d expected 11,0", done_cyc, notbusy);
        end
    endtask

    task automatic test_reset_mid();
        run_xfer(1'b0, LDM_IA, 16'h0001, 30'h300, 4'd0, 1'b0, 0, 0, -1, -1);
        run_xfer(1'b1, LDM_IA, 16'h00F0, 30'h300, 4'd0, 1'b1, 2, 0, -1, 1);
        #1;
        n_checks++;
        if ({busy, done, mem_start, mem_write, wr_en, base_wr_en} !== 6'b0 ||
            {ra, wr_reg, mem_addr, base_new, mem_data_wr, wr_value} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: busy=%b done=%b mem_start=%b mem_addr=%0h expected all 0",
                     busy, done, mem_start, mem_addr);
        end
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (busy || done) seen++;
            end
            n_checks++;
            if (seen != 0) begin
                n_fail++; $display("FAIL reset_mid idle: got %0d busy/done cycles expected 0", seen);
            end
        end
        rf[3] = 32'h0000_7777;
        run_xfer(1'b0, LDM_IB, 16'h0008, 30'h10, 4'd0, 1'b1, 0, 0, -1, -1);
        n_checks++;
        if (done_cyc != 3 || acc_addr.size() != 1 || acc_addr[0] !== 30'h11 || acc_data[0] !== 32'h7777) begin
            n_fail++;
            $display("FAIL reset_mid restart: got done=%0d n=%0d expected done=3 one store 7777@11",
                     done_cyc, acc_addr.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic ld, bwb, exp_bwen;
            ldm_mode md;
            logic [REGS-1:0] lst;
            logic [ADDR_W-1:0] bs, first, fin;
            logic [IW-1:0] br;
            logic [DATA_W-1:0] rf_exp [REGS];
            int lat, n, idx[$], exp_done;
            ld  = 1'($urandom);
            md  = ldm_mode'($urandom_range(0, 3));
            lst = REGS'($urandom) & REGS'($urandom | ($urandom_range(0, 1) ? '1 : 32'h0));
            if ($urandom_range(0, 7) == 0) lst = '0;
            bs  = ADDR_W'($urandom);
            if ($urandom_range(0, 3) == 0) bs = ADDR_W'($urandom_range(0, 3));
            br  = IW'($urandom); bwb = 1'($urandom); lat = $urandom_range(0, 2);
            idx.delete();
            for (int i = 0; i < REGS; i++) if (lst[i]) idx.push_back(i);
            n = idx.size();
            case (md)
                LDM_IA:  begin first = bs;                     fin = bs + ADDR_W'(n); end
                LDM_IB:  begin first = bs + 1;                 fin = bs + ADDR_W'(n); end
                LDM_DA:  begin first = bs - ADDR_W'(n) + 1;    fin = bs - ADDR_W'(n); end
                default: begin first = bs - ADDR_W'(n);        fin = bs - ADDR_W'(n); end
            endcase
            for (int i = 0; i < REGS; i++) rf_exp[i] = rf[i];
            if (ld) for (int k = 0; k < n; k++) rf_exp[idx[k]] = mem_rd(first + ADDR_W'(k));
            exp_done = (n == 0) ? 1 : n * (2 + lat) + 1;
            exp_bwen = bwb && n != 0 && !(ld && lst[br]);
            run_xfer(ld, md, lst, bs, br, bwb, lat, 1, (it % 3 == 0) ? 2 : -1, -1);
            n_checks++;
            if (acc_addr.size() != n) begin
                n_fail++; $display("FAIL rand%0d count: got %0d expected %0d", it, acc_addr.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    n_checks++;
                    if (acc_addr[k] !== first + ADDR_W'(k) || acc_wr[k] !== !ld ||
                        (!ld && acc_data[k] !== rf[idx[k]])) begin
                        n_fail++;
                        $display("FAIL rand%0d acc%0d: got addr=%0h wr=%b data=%0h expected addr=%0h wr=%b",
                                 it, k, acc_addr[k], acc_wr[k], acc_data[k], first + ADDR_W'(k), !ld);
                    end
                end
            end
            n_checks++;
            if (ld && (wq_reg.size() != n || spurious_wr != 0)) begin
                n_fail++; $display("FAIL rand%0d writes: got %0d (+%0d stray) expected %0d",
                                   it, wq_reg.size(), spurious_wr, n);
            end else if (!ld && (wq_reg.size() != 0 || spurious_wr != 0)) begin
                n_fail++; $display("FAIL rand%0d writes: got %0d on store expected 0", it, wq_reg.size());
            end
            for (int i = 0; i < REGS; i++) begin
                n_checks++;
                if (rf[i] !== rf_exp[i]) begin
                    n_fail++; $display("FAIL rand%0d r%0d: got %0h expected %0h", it, i, rf[i], rf_exp[i]);
                end
            end
            n_checks++;
            if (done_cyc != exp_done || notbusy != 0 || unstable != 0) begin
                n_fail++;
                $display("FAIL rand%0d timing: got done=%0d notbusy=%0d unstable=%0d expected done=%0d",
                         it, done_cyc, notbusy, unstable, exp_done);
            end
            n_checks++;
            if (bwen_cnt != int'(exp_bwen) || bwen_bad != 0 || (exp_bwen && bnew_seen !== fin)) begin
                n_fail++;
                $display("FAIL rand%0d base_wb: got cnt=%0d new=%0h expected cnt=%0d new=%0h",
                         it, bwen_cnt, bnew_seen, exp_bwen, fin);
            end
            idle_inputs();
            #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d after_done: got done=%b busy=%b expected 0,0", it, done, busy);
            end
        end
    endtask

    initial begin
        mem_data_rd = '0;
        test_reset();
        test_store_ia();
        test_load_db();
        test_load_base_in_list();
        test_empty();
        test_da_wrap_wait();
        test_reset_mid();
        test_random();
        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_control_ldm.md
# core_control_ldm

Parametrised load/store-multiple sequencer that sits beside `core_control` in the core and takes over the register-file and memory ports for block transfers. It takes a register bitmask, base pointer and addressing mode, and issues one memory transaction per selected register in ascending register order. It performs register writeback for loads and optional base writeback at the end. Register count and data and address widths are generic, so the same block serves the 16-register core and wider variants.

## Interface
- `REGS`, 16, number of architectural registers (power of two, ≥2)
- `DATA_W`, 32, data word width
- `ADDR_W`, 30, word-pointer width (byte address >> 2)

Clock is `clk`; reset is `rst_n`, asynchronous, active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `start`  in  1  begin a transfer; sampled only in IDLE
- `load`  in  1  1 = load (mem→regs), 0 = store
- `mode`  in  2  `ldm_mode`: IA, IB, DA, DB
- `reg_list`  in  REGS  register bitmask; bit i selects register i
- `base`  in  ADDR_W  base word pointer
- `base_reg`  in  $clog2(REGS)  index of base register
- `base_wb`  in  1  request base writeback
- `rd_value`  in  DATA_W  register-file read data for `ra` (combinational)
- `mem_ready`  in  1  memory transaction complete
- `mem_data_rd`  in  DATA_W  load data, valid with `mem_ready`
- `busy`  out  1  sequencer active
- `done`  out  1  one-cycle completion pulse
- `ra`  out  $clog2(REGS)  store source register
- `mem_start`  out  1  one-cycle transaction request
- `mem_write`  out  1  transaction is a store
- `mem_addr`  out  ADDR_W  transaction word address
- `mem_data_wr`  out  DATA_W  store data (= `rd_value`)
- `wr_en`, `wr_reg`, `wr_value`  out  1 / $clog2(REGS) / DATA_W  register writeback
- `base_wr_en`, `base_new`  out  1 / ADDR_W  base writeback

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE, `start`=1:
  - Latch `load`, `base_reg`, `base_wb` and the list.
  - n = popcount(`reg_list`).
  - First address: IA = base; IB = base+1; DA = base−n+1; DB = base−n.
  - Final base: IA/IB = base+n; DA/DB = base−n.
  - All address arithmetic is modulo 2^ADDR_W. Wrap-around is legal and not flagged.
- Empty list (n=0): go straight to FINISH. No memory access. `base_wr_en` stays 0.
- Otherwise go to ISSUE. `ra` = lowest set bit of the list.
- ISSUE: `mem_start`=1 for exactly one cycle, then go to WAIT.
- `mem_addr`, `mem_write` and `ra` are held constant from ISSUE until the `mem_ready` cycle in WAIT.
- WAIT, `mem_ready`=1:
  - If load: `wr_en`=1, `wr_reg`=current reg, `wr_value`=`mem_data_rd`, all in the same cycle (combinational).
  - Clear the current bit and increment the address by 1.
  - If bits remain: go to ISSUE with `ra` = next lowest bit. Else go to FINISH.
- FINISH:
  - `done`=1 for one cycle. `base_wr_en` = `base_wb` && n≠0 && !(load && `base_reg` in list). `base_new` = final base.
  - Then go to IDLE.
- On a load with the base register in the list, the loaded value wins.
- On a store with the base register in the list, the original base value is stored, because `rd_value` is read before any writeback.
- `start` is ignored while `busy`. `mem_ready` is ignored outside WAIT.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- Reset mid-transfer aborts immediately. The in-flight memory transaction is abandoned and no `done` is produced.
- `busy`=1 in ISSUE, WAIT and FINISH.
- Per transfer: ISSUE (1 cycle) + WAIT (≥1 cycle).
- With zero-wait memory, `done` asserts 2n+1 cycles after the `start` sample edge.
- Empty list: `done` asserts 1 cycle after the start edge.
- `start` can be accepted again in the cycle after FINISH, with no dead cycle beyond IDLE.

## Structure
- Add to `core/uarch.sv`: `typedef enum logic[1:0] {LDM_IA, LDM_IB, LDM_DA, LDM_DB} ldm_mode;`.
- The state enum is local to the block.
- Sub-module `core_control_ldm_prio`: generic REGS-bit lowest-set-bit encoder with outputs index and `any`. It is reused for both the first-register select and the next-register select.
- Popcount is an inline function.

## Test plan
- Store IA, list=0x000E, base=0x100, regs r1..r3=0xA,0xB,0xC, zero-wait memory:
  - Stores 0xA@0x100, 0xB@0x101, 0xC@0x102.
  - `done` at cycle 7.
  - `base_wb`=1 → `base_new`=0x103.
- Load DB, list=0x8001, base=0x200, memory returns 0x11 then 0x22:
  - Addresses 0x1FE, 0x1FF.
  - r0=0x11, r15=0x22.
  - `base_new`=0x1FE.
- Load IA, list includes base_reg=r2, `base_wb`=1:
  - r2 gets loaded data.
  - `base_wr_en` never asserts.
- Empty list with `base_wb`=1:
  - `done` 1 cycle after start.
  - No `mem_start`, no `base_wr_en`.
- DA, base=0x0, list=0x0003, mem_ready delayed 3 cycles per access:
  - Addresses 0x3FFFFFFF, 0x0 (wrap).
  - `mem_addr` stable during the waits.
  - `start` pulsed mid-transfer is ignored.
- `rst_n` low during WAIT of the second transfer:
  - All outputs 0 immediately.
  - After release, IDLE with no `done`.
  - A new start works.
